dev_timer: RTL



---
 rtl/dev_timer_pkg.sv | 28 ++
 rtl/dev_bus_slave_if.sv | 110 +++++++++++
 rtl/dev_timer.sv | 174 +++++++++++++++++
 3 files changed

// File: rtl/dev_timer_pkg.sv
// ---------------------------------------------------------------------------
// dev_timer_pkg
//   Shared definitions for Aquila device-bus peripherals:
//   - register word indices seen on addr_i (dev_addr[3:2])
//   - CTRL bit positions for the timer
//   - device base byte used by the SoC address decoder (0xC4xx_xxxx)
//   - bus responder FSM state encoding
// ---------------------------------------------------------------------------
package dev_timer_pkg;

  localparam logic [1:0] REG_CTRL = 2'd0;
  localparam logic [1:0] REG_CMP  = 2'd1;
  localparam logic [1:0] REG_CNT  = 2'd2;
  localparam logic [1:0] REG_STAT = 2'd3;

  localparam int CTRL_EN_BIT    = 0;
  localparam int CTRL_AUTO_BIT  = 1;
  localparam int CTRL_IRQ_BIT   = 2;
  localparam int CTRL_PRESC_LSB = 8;

  localparam logic [7:0] DEV_TIMER_BASE = 8'hC4;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } bus_state_t;

endpackage

// File: rtl/dev_bus_slave_if.sv
// ---------------------------------------------------------------------------
// dev_bus_slave_if
//   Reusable responder front end for the Aquila device bus.
//   IDLE: a strobe latches addr/we/be/data and moves to RESP.
//   RESP: ready_o pulses for exactly this cycle; writes are presented to the
//         device as a byte-merged word, reads return reg_rdata on data_o.
//   Strobes arriving while in RESP are ignored.
// Ports:
//   clk_i, resetn_i        clock, asynchronous active-low reset
//   strobe_i/addr_i/we_i   transaction request from the SoC
//   be_i/data_i            write byte enables and data
//   data_o/ready_o         read data (0 unless ready_o) and completion pulse
//   reg_wr                 commit strobe for the addressed register (RESP & we)
//   reg_addr               latched register index
//   reg_wdata              reg_rdata with the enabled byte lanes replaced
//   reg_clr0               write-one on bit 0 (for W1C status bits)
//   reg_rdata              current value of the addressed register
// ---------------------------------------------------------------------------
module dev_bus_slave_if
  import dev_timer_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              strobe_i,
  input  logic [1:0]        addr_i,
  input  logic              we_i,
  input  logic [XLEN/8-1:0] be_i,
  input  logic [XLEN-1:0]   data_i,
  output logic [XLEN-1:0]   data_o,
  output logic              ready_o,
  output logic              reg_wr,
  output logic [1:0]        reg_addr,
  output logic [XLEN-1:0]   reg_wdata,
  output logic              reg_clr0,
  input  logic [XLEN-1:0]   reg_rdata
);

  localparam int NBYTES = XLEN / 8;

  // Replace only the byte lanes whose enable is set; others keep old_val.
  function automatic logic [XLEN-1:0] merge_bytes(
    input logic [XLEN-1:0]   old_val,
    input logic [XLEN-1:0]   new_val,
    input logic [NBYTES-1:0] be
  );
    logic [XLEN-1:0] res;
    res = old_val;
    for (int i = 0; i < NBYTES; i++) begin
      if (be[i]) res[8*i +: 8] = new_val[8*i +: 8];
    end
    return res;
  endfunction

  bus_state_t              state;
  bus_state_t              state_next;
  logic [1:0]              addr_q;
  logic                    we_q;
  logic [NBYTES-1:0]       be_q;
  logic [XLEN-1:0]         data_q;

  // State register; reset mid-transaction drops straight back to IDLE,
  // so the pending request is neither acknowledged nor committed.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) state <= BUS_IDLE;
    else           state <= state_next;
  end

  // Request latch, loaded only when a strobe is accepted in IDLE.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      addr_q <= '0;
      we_q   <= 1'b0;
      be_q   <= '0;
      data_q <= '0;
    end else if (state == BUS_IDLE && strobe_i) begin
      addr_q <= addr_i;
      we_q   <= we_i;
      be_q   <= be_i;
      data_q <= data_i;
    end
  end

  // Next-state logic: RESP always lasts one cycle.
  always_comb begin
    state_next = state;
    unique case (state)
      BUS_IDLE: if (strobe_i) state_next = BUS_RESP;
      BUS_RESP: state_next = BUS_IDLE;
    endcase
  end

  // Outputs: ready and read data only in RESP; data_o stays 0 otherwise.
  always_comb begin
    ready_o = 1'b0;
    reg_wr  = 1'b0;
    data_o  = '0;
    if (state == BUS_RESP) begin
      ready_o = 1'b1;
      reg_wr  = we_q;
      if (!we_q) data_o = reg_rdata;
    end
  end

  assign reg_addr  = addr_q;
  assign reg_wdata = merge_bytes(reg_rdata, data_q, be_q);
  assign reg_clr0  = be_q[0] & data_q[0];

endmodule

// File: rtl/dev_timer.sv
// ---------------------------------------------------------------------------
// dev_timer
//   Memory-mapped prescaled down-counting timer on the Aquila device bus.
//   Registers: 0 CTRL {PRESC[15:8], IRQ_EN[2], AUTO_RELOAD[1], EN[0]},
//              1 COMPARE (reload value), 2 COUNT (live, writable),
//              3 STATUS {MATCH[0]} sticky, write-1-to-clear.
//   Optional macro DEV_TIMER_IRQ_EN adds a registered interrupt line driven
//   by MATCH gated with IRQ_EN; builds without it tie irq_o low and do not
//   store IRQ_EN.
// Ports:
//   clk_i, resetn_i        clock, asynchronous active-low reset
//   strobe_i/addr_i/we_i   bus request, word index, direction
//   be_i/data_i            write byte enables and data
//   data_o/ready_o         read data and one-cycle completion pulse
//   irq_o                  timer interrupt
// ---------------------------------------------------------------------------
module dev_timer
  import dev_timer_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int PRESC_W = 8
) (
  input  logic              clk_i,
  input  logic              resetn_i,
  input  logic              strobe_i,
  input  logic [1:0]        addr_i,
  input  logic              we_i,
  input  logic [XLEN/8-1:0] be_i,
  input  logic [XLEN-1:0]   data_i,
  output logic [XLEN-1:0]   data_o,
  output logic              ready_o,
  output logic              irq_o
);

  logic                reg_wr;
  logic [1:0]          reg_addr;
  logic [XLEN-1:0]     reg_wdata;
  logic                reg_clr0;
  logic [XLEN-1:0]     reg_rdata;

  logic                ctrl_en;
  logic                ctrl_auto;
  logic                ctrl_irq_en;
  logic [PRESC_W-1:0]  ctrl_presc;
  logic [XLEN-1:0]     compare;
  logic [XLEN-1:0]     count;
  logic                match;
  logic [PRESC_W-1:0]  presc_cnt;

  logic                wr_ctrl;
  logic                wr_cmp;
  logic                wr_cnt;
  logic                wr_stat;
  logic                tick;
  logic                hit;
  logic [XLEN-1:0]     ctrl_word;

  dev_bus_slave_if #(
    .XLEN(XLEN)
  ) u_bus (
    .clk_i     (clk_i),
    .resetn_i  (resetn_i),
    .strobe_i  (strobe_i),
    .addr_i    (addr_i),
    .we_i      (we_i),
    .be_i      (be_i),
    .data_i    (data_i),
    .data_o    (data_o),
    .ready_o   (ready_o),
    .reg_wr    (reg_wr),
    .reg_addr  (reg_addr),
    .reg_wdata (reg_wdata),
    .reg_clr0  (reg_clr0),
    .reg_rdata (reg_rdata)
  );

  assign wr_ctrl = reg_wr && (reg_addr == REG_CTRL);
  assign wr_cmp  = reg_wr && (reg_addr == REG_CMP);
  assign wr_cnt  = reg_wr && (reg_addr == REG_CNT);
  assign wr_stat = reg_wr && (reg_addr == REG_STAT);

  // A tick fires on the cycle the prescaler sits at PRESC; hit marks a tick
  // that finds COUNT already at zero (the match event).
  assign tick = ctrl_en && (presc_cnt == ctrl_presc);
  assign hit  = tick && (count == '0);

  // CTRL as seen by software; unimplemented bits read 0.
  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_EN_BIT]   = ctrl_en;
    ctrl_word[CTRL_AUTO_BIT] = ctrl_auto;
    ctrl_word[CTRL_IRQ_BIT]  = ctrl_irq_en;
    ctrl_word[CTRL_PRESC_LSB +: PRESC_W] = ctrl_presc;
  end

  // Register read mux; also feeds the byte-merge for partial writes.
  always_comb begin
    reg_rdata = '0;
    unique case (reg_addr)
      REG_CTRL: reg_rdata = ctrl_word;
      REG_CMP:  reg_rdata = compare;
      REG_CNT:  reg_rdata = count;
      REG_STAT: reg_rdata[0] = match;
    endcase
  end

  // Prescaler: held at 0 while disabled and restarted by any CTRL write.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i)                presc_cnt <= '0;
    else if (wr_ctrl || !ctrl_en) presc_cnt <= '0;
    else if (tick)                presc_cnt <= '0;
    else                          presc_cnt <= presc_cnt + PRESC_W'(1);
  end

  // CTRL: a bus write beats the one-shot auto-disable in the same cycle.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      ctrl_en    <= 1'b0;
      ctrl_auto  <= 1'b0;
      ctrl_presc <= '0;
    end else if (wr_ctrl) begin
      ctrl_en    <= reg_wdata[CTRL_EN_BIT];
      ctrl_auto  <= reg_wdata[CTRL_AUTO_BIT];
      ctrl_presc <= reg_wdata[CTRL_PRESC_LSB +: PRESC_W];
    end else if (hit && !ctrl_auto) begin
      ctrl_en    <= 1'b0;
    end
  end

`ifdef DEV_TIMER_IRQ_EN
  // IRQ_EN is only storable when the interrupt line exists.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i)    ctrl_irq_en <= 1'b0;
    else if (wr_ctrl) ctrl_irq_en <= reg_wdata[CTRL_IRQ_BIT];
  end
`else
  assign ctrl_irq_en = 1'b0;
`endif

  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i)   compare <= '0;
    else if (wr_cmp) compare <= reg_wdata;
  end

  // COUNT: a bus write discards the tick's decrement or reload.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      count <= '0;
    end else if (wr_cnt) begin
      count <= reg_wdata;
    end else if (tick) begin
      if (count != '0)    count <= count - XLEN'(1);
      else if (ctrl_auto) count <= compare;
    end
  end

  // MATCH is sticky; a new match outranks a simultaneous W1C.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i)                match <= 1'b0;
    else if (hit)                 match <= 1'b1;
    else if (wr_stat && reg_clr0) match <= 1'b0;
  end

`ifdef DEV_TIMER_IRQ_EN
  // Registered interrupt, lagging MATCH by one cycle.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) irq_o <= 1'b0;
    else           irq_o <= match & ctrl_irq_en;
  end
`else
  assign irq_o = 1'b0;
`endif

endmodule
